// File: rtl/seq_mult_cmp.sv
// Iterative shift-add multiplier that compares each new product against the previous one.
// Optional build macro SIGNED_EN: two's-complement operands, signed product and signed compare.
module seq_mult_cmp #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sw,
  input  logic [2:0]       btn,
  output logic [2:0]       led,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   res
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    op1, op2;
  logic [PW-1:0]   mcand, acc, prev, fin_val;
  logic [W-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic            start_q, rise;

`ifdef SIGNED_EN
  logic            sign_q;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct read as unsigned.
  function automatic logic [W-1:0] op_mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  function automatic logic [2:0] cmp3(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
  endfunction

  assign fin_val = sign_q ? -acc : acc;
`else
  function automatic logic [W-1:0] op_mag(input logic [W-1:0] x);
    return x;
  endfunction

  function automatic logic [2:0] cmp3(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  assign fin_val = acc;
`endif

  assign rise = btn[2] & ~start_q;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MUL;
      MUL:     if (cnt == CNT_LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architecturally visible registers; start_q resets high so a held button cannot start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b1;
      op1     <= '0;
      op2     <= '0;
      res     <= '0;
      prev    <= '0;
      led     <= 3'b010;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= btn[2];
      done    <= (state == FIN);
      if (state == IDLE) begin
        if (btn[0]) op1 <= sw;
        if (btn[1]) op2 <= sw;
      end
      if (state == FIN) begin
        prev <= res;
        res  <= fin_val;
        led  <= cmp3(fin_val, res);
      end
    end
  end

  // Shift-add datapath; contents only matter between a start and FIN, so no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (rise) begin
          mcand  <= {{W{1'b0}}, op_mag(op1)};
          mplier <= op_mag(op2);
          acc    <= '0;
          cnt    <= '0;
`ifdef SIGNED_EN
          sign_q <= op1[W-1] ^ op2[W-1];
`endif
        end
      end
      MUL: begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // The LEDs shown after a store always describe the stored product against its predecessor.
  led_tracks_prev: assert property (@(posedge clk) disable iff (rst)
    done |-> (led == cmp3(res, prev)));

endmodule
